// File: rtl/program_counter_ext_if.sv
// Bus between the PDP-8 sequencer and the extended program counter: strobes, operands
// and the PC/field state it exposes.
interface program_counter_ext_if #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned FIELD_BITS = 3
) ();
  logic [WIDTH-1:0]            IN;
  logic                        LD;
  logic                        JMPX;
  logic                        FETCH;
  logic                        CK;
  logic                        LATCH;
  logic                        SKIP;
  logic [FIELD_BITS-1:0]       FLD;
  logic                        CDF;
  logic                        CIF;
  logic                        INTACK;
  logic                        RMF;
  logic [WIDTH-1:0]            PC;
  logic [WIDTH-1:0]            PCLAT;
  logic [FIELD_BITS-1:0]       IFLD;
  logic [FIELD_BITS-1:0]       DFLD;
  logic [FIELD_BITS-1:0]       IB;
  logic [2*FIELD_BITS-1:0]     SF;
  logic [FIELD_BITS+WIDTH-1:0] ADDR;
  logic                        INHIBIT;

  modport master (
    output IN, LD, JMPX, FETCH, CK, LATCH, SKIP, FLD, CDF, CIF, INTACK, RMF,
    input  PC, PCLAT, IFLD, DFLD, IB, SF, ADDR, INHIBIT
  );

  modport slave (
    input  IN, LD, JMPX, FETCH, CK, LATCH, SKIP, FLD, CDF, CIF, INTACK, RMF,
    output PC, PCLAT, IFLD, DFLD, IB, SF, ADDR, INHIBIT
  );
endinterface

// File: rtl/program_counter_ext.sv
// PDP-8 program counter with KM8-E style memory extension: PC/PCLAT plus IF, DF, IB, SF
// and the interrupt-inhibit flag, all driven by rising-edge-detected strobes.
module program_counter_ext #(
  parameter int unsigned     WIDTH      = 12,
  parameter int unsigned     FIELD_BITS = 3,
  parameter logic [WIDTH-1:0] RESET_PC  = 12'o0200
) (
  input logic                   CLK,
  input logic                   RESET_N,
  program_counter_ext_if.slave  bus
);

  localparam int unsigned NumStrb = 8;

  logic [WIDTH-1:0]        pc_q, pc_d;
  logic [WIDTH-1:0]        pclat_q, pclat_d;
  logic [FIELD_BITS-1:0]   if_q, if_d;
  logic [FIELD_BITS-1:0]   df_q, df_d;
  logic [FIELD_BITS-1:0]   ib_q, ib_d;
  logic [2*FIELD_BITS-1:0] sf_q, sf_d;
  logic                    inh_q, inh_d;
  logic [NumStrb-1:0]      hist_q;
  logic [NumStrb-1:0]      strb;
  logic [NumStrb-1:0]      ev;

  logic ld_ev, fetch_ev, ck_ev, skip_ev, cdf_ev, cif_ev, intack_ev, rmf_ev;
  logic [WIDTH-1:0] pc_inc;

  assign strb = {bus.LD, bus.FETCH, bus.CK, bus.SKIP, bus.CDF, bus.CIF, bus.INTACK, bus.RMF};
  assign ev   = strb & ~hist_q;
  assign {ld_ev, fetch_ev, ck_ev, skip_ev, cdf_ev, cif_ev, intack_ev, rmf_ev} = ev;

  assign pc_inc = pc_q + WIDTH'(1);

  always_comb begin
    pc_d    = pc_q;
    pclat_d = pclat_q;
    if_d    = if_q;
    df_d    = df_q;
    ib_d    = ib_q;
    sf_d    = sf_q;
    inh_d   = inh_q;

    // PC group: one action per cycle; FETCH high masks SKIP and CK outright.
    if (ld_ev) begin
      pc_d = bus.IN;
      if (bus.JMPX) begin
        if_d  = ib_q;
        inh_d = 1'b0;
      end
    end else if (fetch_ev) begin
      pclat_d = pc_q;
      pc_d    = pc_inc;
    end else if (!bus.FETCH) begin
      if (skip_ev) begin
        pc_d = pc_inc;
      end else if (ck_ev) begin
        pc_d = pc_inc;
        if (bus.LATCH) begin
          pclat_d = pc_q;
        end
      end
    end

    // Field group runs after the JMPX commit so it overrides IF/IB/INHIBIT when coincident.
    if (intack_ev) begin
      sf_d  = {if_q, df_q};
      if_d  = '0;
      df_d  = '0;
      ib_d  = '0;
      inh_d = 1'b0;
    end else if (rmf_ev) begin
      ib_d  = sf_q[2*FIELD_BITS-1:FIELD_BITS];
      df_d  = sf_q[FIELD_BITS-1:0];
      inh_d = 1'b1;
    end else begin
      if (cif_ev) begin
        ib_d  = bus.FLD;
        inh_d = 1'b1;
      end
      if (cdf_ev) begin
        df_d = bus.FLD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q    <= RESET_PC;
      pclat_q <= '0;
      if_q    <= '0;
      df_q    <= '0;
      ib_q    <= '0;
      sf_q    <= '0;
      inh_q   <= 1'b0;
      hist_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      pclat_q <= pclat_d;
      if_q    <= if_d;
      df_q    <= df_d;
      ib_q    <= ib_d;
      sf_q    <= sf_d;
      inh_q   <= inh_d;
      hist_q  <= strb;
    end
  end

  assign bus.PC      = pc_q;
  assign bus.PCLAT   = pclat_q;
  assign bus.IFLD    = if_q;
  assign bus.DFLD    = df_q;
  assign bus.IB      = ib_q;
  assign bus.SF      = sf_q;
  assign bus.ADDR    = {if_q, pc_q};
  assign bus.INHIBIT = inh_q;

endmodule
